// File: rtl/dbuf_rd_ctrl_if.sv
// Output stream bundle of the DPRAM page reader: data words with a last-of-page
// marker under a valid/ready handshake.
interface dbuf_rd_ctrl_if #(
    parameter int unsigned P_DATA_WIDTH = 64
);
    logic [P_DATA_WIDTH-1:0] data;
    logic                    valid;
    logic                    last;
    logic                    ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/dbuf_rd_ctrl.sv
// Reader-side sequencer for the double-buffered page DPRAM: reads one full page
// in address order, streams it out through a prefetch FIFO, then releases the buffer.
module dbuf_rd_ctrl #(
    parameter int unsigned P_RD_ADDR_WIDTH = 9,
    parameter int unsigned P_RD_DATA_WIDTH = 64,
    parameter int unsigned P_RD_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       rd_busy,
    input  logic [15:0]                dpram_len,
    output logic [P_RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [P_RD_DATA_WIDTH-1:0] rd_dout,
    output logic                       done,
    dbuf_rd_ctrl_if.master             dout,
    output logic                       len_err,
    output logic                       active
);
    localparam int unsigned FIFO_DEPTH = P_RD_LATENCY + 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [16:0] PAGE_DEPTH = 17'(1) << P_RD_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [15:0]                len_q, issued_q, sent_q;
    logic [P_RD_ADDR_WIDTH-1:0] rd_addr_q;
    logic [P_RD_LATENCY-1:0]    inflight_q;
    logic [P_RD_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           fifo_cnt_q, inflight_cnt;
    logic [CNT_W:0]             occupancy;
    logic                       len_over, issue, fifo_wr, pop, out_valid, out_last;
    logic [15:0]                len_clamped;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_over    = {1'b0, dpram_len} > PAGE_DEPTH;
    assign len_clamped = len_over ? PAGE_DEPTH[15:0] : dpram_len;

    // Reads in flight plus words already buffered must fit the FIFO, so the FIFO never overflows.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(P_RD_LATENCY); i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
        end
        occupancy = (CNT_W+1)'(inflight_cnt) + (CNT_W+1)'(fifo_cnt_q);
    end

    assign issue     = (state_q == S_STREAM) && (issued_q < len_q)
                       && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign fifo_wr   = inflight_q[P_RD_LATENCY-1];
    assign out_valid = (fifo_cnt_q != '0);
    assign out_last  = out_valid && (sent_q == len_q - 16'd1);
    assign pop       = out_valid && dout.ready;

    assign dout.valid = out_valid;
    assign dout.last  = out_last;
    assign dout.data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign rd_addr    = rd_addr_q;
    assign done       = (state_q == S_DONE);
    assign len_err    = (state_q == S_LOAD) && len_over;
    assign active     = (state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (en && rd_busy) state_d = S_LOAD;
            S_LOAD:    state_d = (len_clamped == 16'd0) ? S_DONE : S_STREAM;
            S_STREAM:  if (pop && out_last) state_d = S_DONE;
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: if (!rd_busy) state_d = S_SETTLE;
            S_SETTLE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            rd_addr_q  <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LOAD) begin
                len_q     <= len_clamped;
                issued_q  <= '0;
                sent_q    <= '0;
                rd_addr_q <= '0;
            end else begin
                if (issue) begin
                    issued_q  <= issued_q + 16'd1;
                    rd_addr_q <= rd_addr_q + 1'b1;
                end
                if (pop) sent_q <= sent_q + 16'd1;
            end
            inflight_q[0] <= issue;
            for (int i = 1; i < int'(P_RD_LATENCY); i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end
            if (fifo_wr) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_next(rd_ptr_q);
            if (fifo_wr && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!fifo_wr && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr_q] <= rd_dout;
    end
endmodule

// File: tb/tb_dbuf_rd_ctrl.sv
// Self-checking bench for dbuf_rd_ctrl: a two-half DPRAM model with random contents,
// a page-level expectation model and directed page scenarios.
module tb_dbuf_rd_ctrl;
    localparam int AW  = 9;
    localparam int DW  = 64;
    localparam int LAT = 2;
    localparam int D   = 512;

    logic          clk = 1'b0;
    logic          rst, en, rd_busy;
    logic [15:0]   dpram_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_dout;
    logic          done, len_err, active;

    dbuf_rd_ctrl_if #(.P_DATA_WIDTH(DW)) dout_if ();

    dbuf_rd_ctrl #(
        .P_RD_ADDR_WIDTH(AW),
        .P_RD_DATA_WIDTH(DW),
        .P_RD_LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rd_busy  (rd_busy),
        .dpram_len(dpram_len),
        .rd_addr  (rd_addr),
        .rd_dout  (rd_dout),
        .done     (done),
        .dout     (dout_if),
        .len_err  (len_err),
        .active   (active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DPRAM read port model, two-cycle latency, selected half swaps after each page.
    logic [DW-1:0] mem [0:1][0:D-1];
    logic          buf_idx;
    logic [AW-1:0] addr_d1;
    always @(posedge clk) begin
        addr_d1 <= rd_addr;
        rd_dout <= mem[buf_idx][addr_d1];
    end

    // Observations of the current page, relative to the edge that samples rd_busy.
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            t0, mon_rel, done_cnt, lerr_cnt, done_rel, lerr_rel, last_rel;
    int            first_valid_rel, first_active_rel;
    logic [AW-1:0] addr_at [0:15];
    bit            stall_q;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic          page_buf;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                mon_rel = cyc - t0;
                if (mon_rel >= 0 && mon_rel < 16) addr_at[mon_rel] = rd_addr;
                if (done) begin done_cnt++; done_rel = mon_rel; end
                if (len_err) begin lerr_cnt++; lerr_rel = mon_rel; end
                if (active && first_active_rel == -100) first_active_rel = mon_rel;
                if (dout_if.valid && first_valid_rel == -100) first_valid_rel = mon_rel;
                if (stall_q) begin
                    n_checks++;
                    assert (dout_if.valid === 1'b1 && dout_if.data === stall_data
                            && dout_if.last === stall_last)
                    else begin
                        n_fail++;
                        $error("FAIL stall_hold: observed v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                               dout_if.valid, dout_if.data, dout_if.last, stall_data, stall_last);
                    end
                end
                if (dout_if.valid && dout_if.ready) begin
                    got_data.push_back(dout_if.data);
                    got_last.push_back(dout_if.last);
                    if (dout_if.last) last_rel = mon_rel;
                end
                stall_q    = dout_if.valid && !dout_if.ready;
                stall_data = dout_if.data;
                stall_last = dout_if.last;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        done_cnt = 0; lerr_cnt = 0;
        done_rel = -100; lerr_rel = -100; last_rel = -100;
        first_valid_rel = -100; first_active_rel = -100;
        stall_q = 1'b0;
        for (int i = 0; i < 16; i++) addr_at[i] = '1;
    endtask

    // pre: idle cycles between this call and the edge that is expected to sample rd_busy.
    task automatic start_page(input int len, input int pre);
        dpram_len = 16'(len);
        rd_busy   = 1'b1;
        clear_mon();
        t0       = cyc + pre;
        page_buf = buf_idx;
    endtask

    // Runs until done, then models the buffer: release one cycle later, swap one after that.
    task automatic wait_done(input bit rnd, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            dout_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        chk("done_seen", 64'(done_cnt > 0), 64'd1);
        tick();
        rd_busy       = 1'b0;
        dout_if.ready = 1'b1;
        tick();
        buf_idx = ~buf_idx;
    endtask

    task automatic check_page(input int len);
        int l = (len > D) ? D : len;
        chk("word_count", 64'(got_data.size()), 64'(l));
        for (int i = 0; i < got_data.size() && i < l; i++) begin
            chk($sformatf("data[%0d]", i), got_data[i], mem[page_buf][i]);
            chk($sformatf("last[%0d]", i), 64'(got_last[i]), 64'(i == l - 1));
        end
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("len_err_cnt", 64'(lerr_cnt), 64'(len > D));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rd_busy = 1'b0; dpram_len = '0;
        dout_if.ready = 1'b0; buf_idx = 1'b0; t0 = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < D; i++) mem[b][i] = {$urandom, $urandom};
        clear_mon();
        repeat (3) tick();
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(dout_if.valid), 64'd0);
        chk("rst_last", 64'(dout_if.last), 64'd0);
        chk("rst_data", dout_if.data, 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        rst = 1'b0;
        tick();

        // en low blocks the start even with a full buffer
        rd_busy = 1'b1; dpram_len = 16'd4;
        repeat (5) tick();
        chk("en_low_no_start", 64'(active), 64'd0);
        rd_busy = 1'b0;
        en = 1'b1;
        tick();

        // L=4, ready high: exact cycle timing
        dout_if.ready = 1'b1;
        start_page(4, 0);
        wait_done(1'b0, 100);
        check_page(4);
        chk("l4_active_rel", 64'(first_active_rel), 64'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("l4_addr_c%0d", i + 2), 64'(addr_at[i+2]), 64'(i));
        chk("l4_first_valid", 64'(first_valid_rel), 64'(LAT + 3));
        chk("l4_last_rel", 64'(last_rel), 64'd8);
        chk("l4_done_rel", 64'(done_rel), 64'd9);
        repeat (3) tick();

        // empty page
        start_page(0, 0);
        wait_done(1'b0, 50);
        check_page(0);
        chk("l0_no_valid", 64'(first_valid_rel), 64'(-100));
        chk("l0_done_rel", 64'(done_rel), 64'd2);
        repeat (2) tick();
        chk("l0_idle", 64'(active), 64'd0);

        // full page, random backpressure
        start_page(512, 0);
        wait_done(1'b1, 5000);
        check_page(512);
        repeat (3) tick();

        // oversize length clamps to the page depth
        start_page(600, 0);
        wait_done(1'b0, 2000);
        check_page(600);
        chk("len_err_rel", 64'(lerr_rel), 64'd1);
        repeat (3) tick();

        // back-to-back pages; second rd_busy arrives during settle and must be ignored there
        start_page(3, 0);
        wait_done(1'b0, 100);
        check_page(3);
        start_page(5, 1);
        wait_done(1'b0, 100);
        check_page(5);
        chk("b2b_start_rel", 64'(first_active_rel), 64'd1);
        chk("b2b_first_valid", 64'(first_valid_rel), 64'(LAT + 3));
        repeat (3) tick();

        // reset with word 10 of 20 stalled, then restart from address 0
        begin
            int k = 0;
            dout_if.ready = 1'b1;
            start_page(20, 0);
            while (got_data.size() < 10 && k < 100) begin tick(); k++; end
            dout_if.ready = 1'b0;
            chk("stall_count", 64'(got_data.size()), 64'd10);
            repeat (3) tick();
            chk("stall_valid", 64'(dout_if.valid), 64'd1);
            rst = 1'b1;
            #1;
            chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
            chk("mid_rst_valid", 64'(dout_if.valid), 64'd0);
            chk("mid_rst_data", dout_if.data, 64'd0);
            chk("mid_rst_last", 64'(dout_if.last), 64'd0);
            chk("mid_rst_active", 64'(active), 64'd0);
            chk("mid_rst_done", 64'(done), 64'd0);
            repeat (2) tick();
            chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
            rst = 1'b0;
            dout_if.ready = 1'b1;
            clear_mon();
            t0 = cyc;
            wait_done(1'b0, 200);
            check_page(20);
            chk("restart_active_rel", 64'(first_active_rel), 64'd1);
            chk("restart_addr0", 64'(addr_at[2]), 64'd0);
            chk("restart_addr1", 64'(addr_at[3]), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
